muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit.sv | 144 ++++++++++++++
 tb/tb_muldiv_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request and register-file write-back bundle between decode and the RV32M multiply/divide unit.
interface muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic [2:0]      req_funct3;
   logic [4:0]      req_rd;
   logic [XLEN-1:0] req_a;
   logic [XLEN-1:0] req_b;
   logic            kill;
   logic            busy;
   logic            wb_enb;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;

   modport master (
      output req_valid, req_funct3, req_rd, req_a, req_b, kill,
      input  req_ready, busy, wb_enb, wb_rd, wb_data
   );

   modport slave (
      input  req_valid, req_funct3, req_rd, req_a, req_b, kill,
      output req_ready, busy, wb_enb, wb_rd, wb_data
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring-divide steps on operand
// magnitudes, sign fix-up in DONE, fixed latency for every operation.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state_reg, state_next;
   logic [4:0]      count_reg;
   logic [2:0]      funct3_reg;
   logic [4:0]      rd_reg;
   logic [XLEN-1:0] hi_reg, lo_reg, opnd_reg;
   logic            neg_reg;
   logic [4:0]      wb_rd_reg;
   logic [XLEN-1:0] wb_data_reg;

   logic            is_div, a_signed, b_signed, a_neg, b_neg, b_zero, neg_in;
   logic [XLEN-1:0] a_mag, b_mag;

   // Operand decode at acceptance: magnitudes plus the single sign flip the result will need.
   always_comb begin
      is_div   = bus.req_funct3[2];
      a_signed = is_div ? ~bus.req_funct3[0] : (bus.req_funct3[1:0] != 2'b11);
      b_signed = is_div ? ~bus.req_funct3[0] : ~bus.req_funct3[1];
      a_neg    = a_signed & bus.req_a[XLEN-1];
      b_neg    = b_signed & bus.req_b[XLEN-1];
      a_mag    = a_neg ? -bus.req_a : bus.req_a;
      b_mag    = b_neg ? -bus.req_b : bus.req_b;
      b_zero   = (bus.req_b == '0);
      if (!is_div)
         neg_in = a_neg ^ b_neg;
      else if (!bus.req_funct3[1])
         neg_in = (a_neg ^ b_neg) & ~b_zero;
      else
         neg_in = a_neg;
   end

   logic [XLEN:0]   mul_sum, rem_sh, rem_diff;
   logic            rem_ge;
   logic [XLEN-1:0] hi_next, lo_next;

   // One iteration: hi/lo hold the product halves, or remainder/quotient when dividing.
   always_comb begin
      mul_sum  = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
      rem_sh   = {hi_reg, lo_reg[XLEN-1]};
      rem_diff = rem_sh - {1'b0, opnd_reg};
      // A set top bit means the shifted remainder already exceeds any 32-bit divisor.
      rem_ge   = rem_sh[XLEN] | ~rem_diff[XLEN];
      if (funct3_reg[2]) begin
         hi_next = rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
         lo_next = {lo_reg[XLEN-2:0], rem_ge};
      end else begin
         hi_next = mul_sum[XLEN:1];
         lo_next = {mul_sum[0], lo_reg[XLEN-1:1]};
      end
   end

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, result;

   always_comb begin
      prod_fix = neg_reg ? -{hi_reg, lo_reg} : {hi_reg, lo_reg};
      quo_fix  = neg_reg ? -lo_reg : lo_reg;
      rem_fix  = neg_reg ? -hi_reg : hi_reg;
      case (funct3_reg)
         3'd0:             result = prod_fix[XLEN-1:0];
         3'd1, 3'd2, 3'd3: result = prod_fix[2*XLEN-1:XLEN];
         3'd4, 3'd5:       result = quo_fix;
         default:          result = rem_fix;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (bus.req_valid && !bus.kill) state_next = BUSY;
         BUSY: begin
            if (bus.kill)
               state_next = IDLE;
            else if (count_reg == 5'd31)
               state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = (state_reg == IDLE) && !reset;
      bus.busy      = (state_reg != IDLE);
      bus.wb_enb    = (state_reg == DONE) && !bus.kill && (rd_reg != 5'd0);
      bus.wb_rd     = (state_reg == DONE) ? rd_reg : wb_rd_reg;
      bus.wb_data   = (state_reg == DONE) ? result : wb_data_reg;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg   <= '0;
         funct3_reg  <= '0;
         rd_reg      <= '0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         opnd_reg    <= '0;
         neg_reg     <= 1'b0;
         wb_rd_reg   <= '0;
         wb_data_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.req_valid && !bus.kill) begin
                  count_reg  <= '0;
                  funct3_reg <= bus.req_funct3;
                  rd_reg     <= bus.req_rd;
                  neg_reg    <= neg_in;
                  hi_reg     <= '0;
                  lo_reg     <= is_div ? a_mag : b_mag;
                  opnd_reg   <= is_div ? b_mag : a_mag;
               end
            end
            BUSY: begin
               hi_reg    <= hi_next;
               lo_reg    <= lo_next;
               count_reg <= count_reg + 5'd1;
            end
            DONE: begin
               wb_rd_reg   <= rd_reg;
               wb_data_reg <= result;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, latency, kill, reset and rd=0 cases.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      int          due;
      string       name;
   } exp_t;

   exp_t sb[$];

   muldiv_unit_if #(.XLEN(32)) bus ();
   muldiv_unit #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: every write pulse pops the oldest expectation and checks rd, data and cycle.
   always @(negedge clk) begin : mon
      exp_t e;
      if (reset === 1'b0 && bus.wb_enb === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_wb actual rd=%0d data=%h required no write", bus.wb_rd, bus.wb_data);
         end else begin
            e = sb.pop_front();
            $display("wb %s rd=%0d data=%h cyc=%0d", e.name, bus.wb_rd, bus.wb_data, cyc);
            chk({e.name, "_rd"}, {27'd0, bus.wb_rd}, {27'd0, e.rd});
            chk({e.name, "_data"}, bus.wb_data, e.data);
            chk({e.name, "_latency"}, cyc, e.due);
         end
      end
   end

   // Present a request, hold it until accepted, then drop it after the accepting edge.
   task automatic issue(input logic [2:0] f, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] r, input bit expect_wb,
                        input string name, output int waited);
      exp_t e;
      bus.req_funct3 = f;
      bus.req_rd     = rd;
      bus.req_a      = a;
      bus.req_b      = b;
      bus.req_valid  = 1'b1;
      waited = 0;
      while (bus.req_ready !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (bus.req_ready !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL %s_accept actual ready=%b required 1", name, bus.req_ready);
      end else if (expect_wb) begin
         e.rd   = rd;
         e.data = r;
         e.due  = cyc + 33;
         e.name = name;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus.busy !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy !== 1'b0) begin
         checks++;
         failures++;
         $display("FAIL %s_idle actual busy=%b required 0", name, bus.busy);
      end
   endtask

   task automatic run(input logic [2:0] f, input logic [4:0] rd, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] r, input string name);
      int w;
      issue(f, rd, a, b, r, 1'b1, name, w);
      wait_idle(name);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual cyc=%0d required finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w, acc, bcnt;
      reset          = 1'b1;
      bus.req_valid  = 1'b0;
      bus.kill       = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_rd     = 5'd0;
      bus.req_a      = 32'd0;
      bus.req_b      = 32'd0;
      repeat (2) @(negedge clk);
      chk("reset_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("reset_busy", {31'd0, bus.busy}, 32'd0);
      chk("reset_wb_enb", {31'd0, bus.wb_enb}, 32'd0);
      chk("reset_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
      chk("reset_wb_data", bus.wb_data, 32'd0);
      reset = 1'b0;
      #1;

      issue(3'd0, 5'd5, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1, "mul", w);
      chk("first_accept_wait", w, 0);
      wait_idle("mul");
      // Previous write-back must stay on wb_rd/wb_data while the next op runs.
      issue(3'd1, 5'd6, 32'h80000000, 32'h80000000, 32'h40000000, 1'b1, "mulh_min", w);
      repeat (3) @(negedge clk);
      chk("hold_wb_rd", {27'd0, bus.wb_rd}, 32'd5);
      chk("hold_wb_data", bus.wb_data, 32'hFFFFFFEB);
      wait_idle("mulh_min");

      run(3'd3, 5'd7,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
      run(3'd2, 5'd8,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_neg");
      run(3'd2, 5'd29, 32'd2,        32'hFFFFFFFF, 32'h00000001, "mulhsu_pos");
      run(3'd1, 5'd9,  32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, "mulh_neg");
      run(3'd0, 5'd10, 32'd12345,    32'd6789,     32'h04FED79D, "mul_pos");
      run(3'd4, 5'd11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div");
      run(3'd6, 5'd12, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem");
      run(3'd5, 5'd13, 32'd100,      32'd7,        32'd14,       "divu");
      run(3'd7, 5'd14, 32'd100,      32'd7,        32'd2,        "remu");
      run(3'd4, 5'd15, 32'd5,        32'd0,        32'hFFFFFFFF, "div_by0");
      run(3'd6, 5'd16, 32'd5,        32'd0,        32'd5,        "rem_by0");
      run(3'd4, 5'd17, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
      run(3'd6, 5'd18, 32'h80000000, 32'hFFFFFFFF, 32'd0,        "rem_ovf");
      run(3'd4, 5'd19, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, "div_neg_by0");
      run(3'd6, 5'd20, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, "rem_neg_by0");
      run(3'd4, 5'd21, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, "div_pos_neg");
      run(3'd6, 5'd22, 32'd7,        32'hFFFFFFFE, 32'd1,        "rem_pos_neg");
      run(3'd5, 5'd23, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, "divu_by0");
      run(3'd5, 5'd24, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, "divu_big");
      run(3'd7, 5'd30, 32'hFFFFFFFF, 32'd16,       32'h0000000F, "remu_big");

      // Kill ten cycles into an operation: back to IDLE, no write.
      issue(3'd0, 5'd25, 32'd3, 32'd4, 32'd12, 1'b0, "kill_busy", w);
      repeat (9) @(negedge clk);
      bus.kill = 1'b1;
      @(negedge clk);
      bus.kill = 1'b0;
      chk("kill_busy_busy", {31'd0, bus.busy}, 32'd0);
      chk("kill_busy_ready", {31'd0, bus.req_ready}, 32'd1);
      repeat (40) @(negedge clk);

      // Reset five cycles into an operation, then accept on the first edge after release.
      issue(3'd0, 5'd26, 32'd3, 32'd4, 32'd12, 1'b0, "reset_mid", w);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_mid_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("rst_mid_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
      chk("rst_mid_wb_data", bus.wb_data, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      issue(3'd3, 5'd27, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, "after_reset", w);
      chk("after_reset_wait", w, 0);
      wait_idle("after_reset");

      // Kill during DONE must suppress that cycle's write pulse.
      issue(3'd0, 5'd28, 32'd3, 32'd4, 32'd12, 1'b0, "kill_done", w);
      repeat (31) @(negedge clk);
      @(posedge clk);
      #1;
      chk("kill_done_pre_enb", {31'd0, bus.wb_enb}, 32'd1);
      bus.kill = 1'b1;
      #1;
      chk("kill_done_enb", {31'd0, bus.wb_enb}, 32'd0);
      @(posedge clk);
      #1;
      bus.kill = 1'b0;
      chk("kill_done_busy", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);

      // rd=0 with req_valid held through the whole operation.
      bus.req_funct3 = 3'd0;
      bus.req_rd     = 5'd0;
      bus.req_a      = 32'd6;
      bus.req_b      = 32'd7;
      bus.req_valid  = 1'b1;
      chk("rd0_ready", {31'd0, bus.req_ready}, 32'd1);
      acc  = 0;
      bcnt = 0;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) bcnt++;
         if (bus.req_ready === 1'b1) acc++;
         if (k == 33) begin
            chk("rd0_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
            chk("rd0_wb_data", bus.wb_data, 32'd42);
            chk("rd0_wb_enb", {31'd0, bus.wb_enb}, 32'd0);
            bus.req_valid = 1'b0;
         end
      end
      @(negedge clk);
      chk("rd0_busy_after", {31'd0, bus.busy}, 32'd0);
      chk("rd0_busy_cycles", bcnt, 32'd33);
      chk("rd0_extra_accepts", acc, 32'd0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
